// File: rtl/mem_responder.sv
// Block-interface memory responder: one outstanding read or write, fixed programmable latency,
// single-cycle mem_ready completion pulse and a sticky protocol-violation flag.
module mem_responder #(
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [27:0]            mem_addr,
  input  logic [BLOCK_WIDTH-1:0] mem_wdata,
  output logic [BLOCK_WIDTH-1:0] mem_rdata,
  output logic                   mem_ready,
  output logic                   busy,
  output logic                   proto_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   op_write_q, op_write_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
  logic                   proto_q, proto_d;
  logic [BLOCK_WIDTH-1:0] mem_q [DEPTH];

  logic req;
  logic req_held;

  assign req      = mem_read | mem_write;
  // The requester must keep its own request line high until it sees mem_ready.
  assign req_held = op_write_q ? mem_write : mem_read;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    proto_d    = proto_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          op_write_d = mem_write;
          idx_d      = mem_addr[ADDR_BITS-1:0];
          wdata_d    = mem_wdata;
          cnt_d      = 4'(LATENCY - 1);
          if (mem_read && mem_write) proto_d = 1'b1;
          state_d    = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        if (!req_held) proto_d = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp: begin
        if (!req_held) proto_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_ready = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign proto_err = proto_q;
  assign mem_rdata = mem_ready ? mem_q[idx_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      proto_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      proto_q    <= proto_d;
      // Commit on the edge that ends RESP so a read accepted next cycle sees it.
      if (state_q == StResp && op_write_q) mem_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of block transactions plus hand-written
// reset, protocol-error and abort sequences.
module tb_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready, busy, proto_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam int LAT = 4;
  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] DB = 128'hBBBB_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] DC = 128'hCCCC_CCCC_0000_FFFF_1234_5678_9ABC_DEF0;
  localparam logic [127:0] DD = 128'hDDDD_0000_DDDD_0000_DDDD_0000_DDDD_0000;

  mem_responder #(.BLOCK_WIDTH(128), .ADDR_BITS(8), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic         chain;
    logic         chk_rdata;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts a request in the current cycle (called #1 after a posedge), holds it until
  // mem_ready, then drops it #1 after the edge ending RESP.
  task automatic run_txn(input logic rd, input logic wr, input logic [27:0] addr,
                         input logic [127:0] wd, output int start, output int rdy,
                         output logic [127:0] rdata, output logic busy_ok, output logic perr);
    start = cyc;
    mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
    busy_ok = 1'b1; rdy = -1; rdata = '0; perr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== (cyc > start)) busy_ok = 1'b0;
      if (mem_ready === 1'b1) begin
        rdy = cyc; rdata = mem_rdata; perr = proto_err;
        break;
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int           start, rdy, prev_rdy, nready;
    logic [127:0] rdata;
    logic         busy_ok, perr;

    vecs[0] = '{1'b0, 1'b1, 28'h12,      D1,   1'b0, 1'b0, '0};
    vecs[1] = '{1'b1, 1'b0, 28'h12,      '0,   1'b1, 1'b1, D1};
    vecs[2] = '{1'b0, 1'b1, 28'h0000103, DA,   1'b0, 1'b0, '0};
    vecs[3] = '{1'b1, 1'b0, 28'h0000003, '0,   1'b0, 1'b1, DA};
    vecs[4] = '{1'b0, 1'b1, 28'h20,      DB,   1'b0, 1'b0, '0};
    vecs[5] = '{1'b1, 1'b0, 28'h21,      '0,   1'b1, 1'b1, '0};
    vecs[6] = '{1'b1, 1'b0, 28'h20,      '0,   1'b0, 1'b1, DB};

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 128'(mem_ready), 128'(0));
    check("reset_rdata", mem_rdata, '0);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_proto", 128'(proto_err), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    while (cyc != 10) begin @(posedge clk); #1; end
    run_txn(1'b1, 1'b0, 28'h05, '0, start, rdy, rdata, busy_ok, perr);
    check("first_read_cycle", 128'(rdy), 128'(14));
    check("first_read_rdata", rdata, '0);
    check("first_read_busy", 128'(busy_ok), 128'(1));

    prev_rdy = rdy;
    for (int v = 0; v < 7; v++) begin
      if (!vecs[v].chain) begin @(posedge clk); #1; end
      run_txn(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, start, rdy, rdata,
              busy_ok, perr);
      check($sformatf("vec%0d_latency", v), 128'(rdy - start), 128'(LAT));
      check($sformatf("vec%0d_busy", v), 128'(busy_ok), 128'(1));
      if (vecs[v].chain) check($sformatf("vec%0d_gap", v), 128'(rdy - prev_rdy), 128'(LAT + 1));
      if (vecs[v].chk_rdata) check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
      check($sformatf("vec%0d_proto", v), 128'(perr), 128'(0));
      prev_rdy = rdy;
    end

    // Read and write together: handled as a write and flagged.
    @(posedge clk); #1;
    run_txn(1'b1, 1'b1, 28'h30, DC, start, rdy, rdata, busy_ok, perr);
    check("dual_latency", 128'(rdy - start), 128'(LAT));
    check("dual_proto", 128'(perr), 128'(1));
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 28'h30, '0, start, rdy, rdata, busy_ok, perr);
    check("dual_readback", rdata, DC);

    do_reset();
    @(negedge clk);
    check("proto_cleared", 128'(proto_err), 128'(0));
    @(posedge clk); #1;

    // Read dropped in the middle of WAIT still completes on time.
    start = cyc; rdy = -1;
    mem_read = 1'b1; mem_addr = 28'h05;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin rdy = cyc; break; end
    end
    check("drop_latency", 128'(rdy - start), 128'(LAT));
    check("drop_proto", 128'(proto_err), 128'(1));
    @(posedge clk); #1;

    do_reset();
    @(posedge clk); #1;

    // Reset two cycles into a write aborts it without a completion pulse.
    mem_write = 1'b1; mem_addr = 28'h40; mem_wdata = DD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    nready = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_ready === 1'b1) nready++;
    end
    check("abort_no_ready", 128'(nready), 128'(0));
    check("abort_proto", 128'(proto_err), 128'(0));
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 28'h40, '0, start, rdy, rdata, busy_ok, perr);
    check("abort_latency", 128'(rdy - start), 128'(LAT));
    check("abort_rdata", rdata, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the cache's 128-bit block interface (mem_read, mem_write, mem_addr, mem_wdata, mem_rdata, mem_ready).
- Accepts one block read or block write at a time. Holds DEPTH blocks of storage. Completes each request after a programmable latency by pulsing mem_ready for one cycle.
- Serves as the data-memory model for cache verification and as the template for the real memory controller.

Parameters:
- BLOCK_WIDTH, 128, data bits per block.
- ADDR_BITS, 8, low mem_addr bits used as storage index; DEPTH = 2**ADDR_BITS.
- LATENCY, 4, cycles from request acceptance to mem_ready; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- mem_read  input  1  block read request, level, held until mem_ready.
- mem_write  input  1  block write request, level, held until mem_ready.
- mem_addr  input  28  block address; bits [ADDR_BITS-1:0] index storage, upper bits ignored (aliasing).
- mem_wdata  input  BLOCK_WIDTH  write data.
- mem_rdata  output  BLOCK_WIDTH  read data, valid only while mem_ready=1.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high from the cycle after acceptance through the mem_ready cycle.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (synchronous, active-high):
  - Next state IDLE; counter 0; all storage blocks 0.
  - mem_ready=0, mem_rdata=0, busy=0, proto_err=0.
  - Reset mid-request aborts it: a pending write is not committed and no mem_ready follows.
- States:
  - IDLE: when (mem_read|mem_write)=1 at a clock edge, latch op, mem_addr[ADDR_BITS-1:0] and mem_wdata; load counter with LATENCY-1; go to WAIT. If LATENCY=1, go straight to RESP.
  - WAIT: decrement counter each cycle; at 0 go to RESP.
  - RESP: drive mem_ready=1 for exactly this cycle; return to IDLE next cycle.
- Latency: request first high in the IDLE cycle T gives mem_ready=1 in cycle T+LATENCY. Back-to-back requests cost LATENCY+1 cycles each, because the cycle after RESP is IDLE.
- Read: in RESP, mem_rdata = storage[latched index]. It reflects any write committed before that cycle. mem_rdata=0 whenever mem_ready=0.
- Write: storage[latched index] <= latched wdata at the clock edge ending RESP. A read accepted in the following cycle returns the new data.
- Inputs are sampled only at acceptance. Changes to addr/wdata during WAIT/RESP are ignored.
- Simultaneous mem_read & mem_write at acceptance: treated as a write; proto_err set.
- Request deasserted during WAIT/RESP: proto_err set. The transaction still completes (write committed, mem_ready pulsed).
- Request still high in the IDLE cycle right after RESP: treated as a new request. This matches the cache changing state on mem_ready: the WB cycle is followed by a FETCH read.
- proto_err clears only on rst.

Test Plan:
- Reset, LATENCY=4:
  - mem_read=1, addr=0x05 at cycle 10 -> mem_ready=1 only at cycle 14, mem_rdata=0, busy high cycles 11-14.
- Write then read:
  - write addr=0x12, wdata=0x0123_4567_89AB_CDEF_0011_2233_4455_6677, held until ready; then mem_read addr=0x12 the next cycle.
  - -> second mem_ready exactly LATENCY+1 cycles after the first, rdata equals the written value.
- Aliasing: write addr=0x0000103 data=A, then read addr=0x0000003 -> rdata=A.
- Cache WB->FETCH sequence:
  - write addr=0x20 data=B; in the cycle after its ready, mem_read addr=0x21.
  - -> read accepted immediately, returns 0. A later read of 0x20 returns B.
- Protocol errors:
  - mem_read & mem_write both high with addr=0x30 data=C -> treated as write, proto_err=1, later read of 0x30 = C.
  - separately, read dropped mid-WAIT -> mem_ready still pulses at T+LATENCY, proto_err=1.
- Reset mid-write: write addr=0x40 data=D, rst at T+2 -> no mem_ready, proto_err=0, read of 0x40 after reset returns 0.
